// File: rtl/seq_ctrl_ws.sv
// Eight-phase VeriRISC instruction sequencer with memory wait states, timeout,
// sticky halt/resume, single-step pausing and a saturating retired-instruction count.
package typedefs;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcodes_t;
endpackage

module seq_ctrl_ws
  import typedefs::*;
#(
  parameter bit          WAIT_EN      = 1'b1,
  parameter int unsigned WAIT_TIMEOUT = 15,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  typedefs::opcodes_t      opcode,
  input  logic                    zero,
  input  logic                    mem_ready,
  input  logic                    resume,
  input  logic                    step_mode,
  input  logic                    step,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    load_ir,
  output logic                    load_ac,
  output logic                    load_pc,
  output logic                    inc_pc,
  output logic                    halt,
  output logic                    bus_err,
  output logic [3:0]              phase,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8,
    PAUSED     = 4'd9,
    ERROR      = 4'd10
  } state_t;

  localparam int unsigned WCW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  state_t                 state_q, state_d;
  logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]   instr_count_q, instr_count_d;

  logic rdy, rd_op, wait_ph, timed_out, retire;

  always_comb begin
    rdy       = mem_ready || !WAIT_EN;
    rd_op     = opcode inside {ADD, AND, XOR, LDA};
    timed_out = (WAIT_TIMEOUT != 0) && (wait_cnt_q == WCW'(WAIT_TIMEOUT - 1));

    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    load_ir  = 1'b0;
    load_ac  = 1'b0;
    load_pc  = 1'b0;
    inc_pc   = 1'b0;
    halt     = 1'b0;
    bus_err  = 1'b0;
    wait_ph  = 1'b0;
    retire   = 1'b0;
    state_d  = state_q;

    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: begin
        mem_rd  = 1'b1;
        state_d = INST_LOAD;
      end
      INST_LOAD: begin
        mem_rd  = 1'b1;
        load_ir = rdy;
        wait_ph = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        mem_rd  = 1'b1;
        load_ir = 1'b1;
        state_d = OP_ADDR;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        if (opcode == HLT) begin
          halt    = 1'b1;
          state_d = HALTED;
        end else begin
          state_d = OP_FETCH;
        end
      end
      OP_FETCH: begin
        mem_rd  = rd_op;
        state_d = ALU_OP;
      end
      ALU_OP: begin
        state_d = STORE;
        if (rd_op) begin
          mem_rd  = 1'b1;
          load_ac = rdy;
          wait_ph = 1'b1;
        end else if (opcode == SKZ && zero) begin
          inc_pc = 1'b1;
        end else if (opcode == JMP) begin
          load_pc = 1'b1;
        end
      end
      STORE: begin
        if (rd_op) begin
          mem_rd  = 1'b1;
          load_ac = 1'b1;
        end
        if (opcode == JMP) begin
          inc_pc  = 1'b1;
          load_pc = 1'b1;
        end
        if (opcode == STO) begin
          mem_wr  = 1'b1;
          wait_ph = 1'b1;
        end
        retire  = 1'b1;
        state_d = step_mode ? PAUSED : INST_ADDR;
      end
      HALTED: begin
        halt = 1'b1;
        if (resume) state_d = INST_ADDR;
      end
      PAUSED: begin
        if (step) state_d = INST_ADDR;
      end
      ERROR: begin
        halt    = 1'b1;
        bus_err = 1'b1;
      end
      default: state_d = INST_ADDR;
    endcase

    // A stall overrides whatever advance the state decode chose above.
    wait_cnt_d = '0;
    if (wait_ph && !rdy) begin
      retire = 1'b0;
      if (timed_out) begin
        state_d = ERROR;
      end else begin
        state_d    = state_q;
        wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
    end

    instr_count_d = instr_count_q;
    if (retire && !(&instr_count_q)) instr_count_d = instr_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INST_ADDR;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign phase       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_seq_ctrl_ws.sv
// Directed bench for seq_ctrl_ws: per-cycle phase/strobe checks against
// hand-written expectations, plus a CNT_WIDTH=2 instance for count saturation.
module tb_seq_ctrl_ws;
  import typedefs::*;

  localparam logic [7:0] RD  = 8'h80;
  localparam logic [7:0] WR  = 8'h40;
  localparam logic [7:0] IR  = 8'h20;
  localparam logic [7:0] AC  = 8'h10;
  localparam logic [7:0] PC  = 8'h08;
  localparam logic [7:0] INC = 8'h04;
  localparam logic [7:0] HB  = 8'h02;
  localparam logic [7:0] BE  = 8'h01;
  localparam logic [7:0] NO  = 8'h00;

  // Expected strobes for phases 3..0 (fetch) and 7..4 (execute), phase 0 in the low byte.
  localparam logic [31:0] FETCH_E = {RD | IR, RD | IR, RD, NO};
  localparam logic [63:0] RDOP_E  = {RD | AC, RD | AC, RD, INC, FETCH_E};
  localparam logic [63:0] JMP_E   = {INC | PC, PC, NO, INC, FETCH_E};
  localparam logic [63:0] SKZ1_E  = {NO, INC, NO, INC, FETCH_E};
  localparam logic [63:0] SKZ0_E  = {NO, NO, NO, INC, FETCH_E};

  logic clk = 1'b0;
  logic rst, zero, mem_ready, resume, step_mode, step;
  opcodes_t opcode;

  logic mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt, bus_err;
  logic [3:0]  phase;
  logic [15:0] instr_count;

  logic mem_rd2, mem_wr2, load_ir2, load_ac2, load_pc2, inc_pc2, halt2, bus_err2;
  logic [3:0] phase2;
  logic [1:0] instr_count2;

  logic [7:0] strb;
  assign strb = {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt, bus_err};

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_ctrl_ws #(.WAIT_EN(1'b1), .WAIT_TIMEOUT(15), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .step_mode(step_mode), .step(step),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir), .load_ac(load_ac),
    .load_pc(load_pc), .inc_pc(inc_pc), .halt(halt), .bus_err(bus_err),
    .phase(phase), .instr_count(instr_count)
  );

  seq_ctrl_ws #(.WAIT_EN(1'b1), .WAIT_TIMEOUT(15), .CNT_WIDTH(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .resume(resume), .step_mode(step_mode), .step(step),
    .mem_rd(mem_rd2), .mem_wr(mem_wr2), .load_ir(load_ir2), .load_ac(load_ac2),
    .load_pc(load_pc2), .inc_pc(inc_pc2), .halt(halt2), .bus_err(bus_err2),
    .phase(phase2), .instr_count(instr_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [3:0] ep, input logic [7:0] es);
    #1;
    chk({tag, " phase"}, 32'(phase), 32'(ep));
    chk({tag, " strobes"}, 32'(strb), 32'(es));
  endtask

  task automatic cyc(input string tag, input logic [3:0] ep, input logic [7:0] es);
    look(tag, ep, es);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input opcodes_t op, input logic z);
    logic [31:0] f;
    f = FETCH_E;
    opcode = op;
    zero   = z;
    for (int p = 0; p < 4; p++) cyc(tag, 4'(p), f[8*p +: 8]);
  endtask

  task automatic instr(input string tag, input opcodes_t op, input logic z, input logic [63:0] e);
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) cyc(tag, 4'(p), e[8*p +: 8]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1; resume = 1'b0;
    step_mode = 1'b0; step = 1'b0; opcode = ADD;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    look("reset", 4'd0, NO);
    chk("reset count", 32'(instr_count), 32'd0);

    instr("add", ADD, 1'b0, RDOP_E);
    look("add done", 4'd0, NO);
    chk("add count", 32'(instr_count), 32'd1);

    instr("jmp", JMP, 1'b0, JMP_E);
    instr("skz z1", SKZ, 1'b1, SKZ1_E);
    instr("skz z0", SKZ, 1'b0, SKZ0_E);
    chk("jmp/skz count", 32'(instr_count), 32'd4);

    fetch("hlt", HLT, 1'b0);
    cyc("hlt op_addr", 4'd4, INC | HB);
    repeat (20) cyc("halted", 4'd8, HB);
    chk("hlt count", 32'(instr_count), 32'd4);
    resume = 1'b1;
    cyc("halted resume", 4'd8, HB);
    resume = 1'b0;
    look("after resume", 4'd0, NO);

    fetch("sto3", STO, 1'b0);
    cyc("sto3", 4'd4, INC);
    cyc("sto3", 4'd5, NO);
    cyc("sto3", 4'd6, NO);
    mem_ready = 1'b0;
    repeat (3) cyc("sto3 stall", 4'd7, WR);
    mem_ready = 1'b1;
    cyc("sto3 ready", 4'd7, WR);
    look("sto3 done", 4'd0, NO);
    chk("sto3 count", 32'(instr_count), 32'd5);

    opcode = ADD; zero = 1'b0;
    cyc("add wait", 4'd0, NO);
    cyc("add wait", 4'd1, RD);
    mem_ready = 1'b0;
    cyc("ir stall", 4'd2, RD);
    cyc("ir stall", 4'd2, RD);
    mem_ready = 1'b1;
    cyc("ir ready", 4'd2, RD | IR);
    cyc("add wait", 4'd3, RD | IR);
    cyc("add wait", 4'd4, INC);
    cyc("add wait", 4'd5, RD);
    mem_ready = 1'b0;
    cyc("ac stall", 4'd6, RD);
    mem_ready = 1'b1;
    cyc("ac ready", 4'd6, RD | AC);
    cyc("add wait", 4'd7, RD | AC);
    look("add wait done", 4'd0, NO);
    chk("add wait count", 32'(instr_count), 32'd6);

    fetch("sto14", STO, 1'b0);
    cyc("sto14", 4'd4, INC);
    cyc("sto14", 4'd5, NO);
    cyc("sto14", 4'd6, NO);
    mem_ready = 1'b0;
    repeat (14) cyc("sto14 stall", 4'd7, WR);
    mem_ready = 1'b1;
    cyc("sto14 last-chance ready", 4'd7, WR);
    look("sto14 done", 4'd0, NO);
    chk("sto14 count", 32'(instr_count), 32'd7);

    fetch("sto to", STO, 1'b0);
    cyc("sto to", 4'd4, INC);
    cyc("sto to", 4'd5, NO);
    cyc("sto to", 4'd6, NO);
    mem_ready = 1'b0;
    repeat (15) cyc("sto to stall", 4'd7, WR);
    look("error entry", 4'd10, HB | BE);
    resume = 1'b1; step = 1'b1;
    cyc("error resume", 4'd10, HB | BE);
    resume = 1'b0; step = 1'b0; mem_ready = 1'b1;
    cyc("error hold", 4'd10, HB | BE);
    chk("error count", 32'(instr_count), 32'd7);
    rst = 1'b1;
    cyc("error rst", 4'd10, HB | BE);
    rst = 1'b0;
    look("error cleared", 4'd0, NO);
    chk("error cleared count", 32'(instr_count), 32'd0);

    step_mode = 1'b1;
    instr("lda step1", LDA, 1'b0, RDOP_E);
    cyc("paused1", 4'd9, NO);
    chk("paused1 count", 32'(instr_count), 32'd1);
    resume = 1'b1;
    cyc("paused resume", 4'd9, NO);
    resume = 1'b0;
    step = 1'b1;
    cyc("paused step", 4'd9, NO);
    step = 1'b0;
    instr("lda step2", LDA, 1'b0, RDOP_E);
    look("paused2", 4'd9, NO);
    chk("paused2 count", 32'(instr_count), 32'd2);
    step_mode = 1'b0;
    cyc("paused no mode", 4'd9, NO);
    cyc("paused no mode", 4'd9, NO);
    step = 1'b1;
    cyc("paused step2", 4'd9, NO);
    step = 1'b0;
    look("unpaused", 4'd0, NO);

    fetch("lda rst", LDA, 1'b0);
    cyc("lda rst", 4'd4, INC);
    cyc("lda rst", 4'd5, RD);
    rst = 1'b1;
    cyc("lda rst", 4'd6, RD | AC);
    rst = 1'b0;
    look("mid rst", 4'd0, NO);
    chk("mid rst count", 32'(instr_count), 32'd0);

    for (int k = 1; k <= 5; k++) begin
      instr("lda sat", LDA, 1'b0, RDOP_E);
      chk("count16", 32'(instr_count), 32'(k));
      chk("count2 sat", 32'(instr_count2), (k > 3) ? 32'd3 : 32'(k));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
